// File: rtl/fib_pkg.sv
// rtl/fib_pkg.sv - shared state encoding and default sizes for the Fibonacci blocks
package fib_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SEARCH = 2'd1,
      DONE   = 2'd2
   } fib_state_t;

   localparam int FIB_WIDTH  = 32;
   localparam int FIB_IDX_W  = 6;
   // Largest index whose term fits in 32 bits: fib(47) = 2971215073.
   localparam int MAX_IDX_32 = 47;

endpackage

// File: rtl/fib_step_reg.sv
// rtl/fib_step_reg.sv - prev/curr Fibonacci register pair with carry-out adder
// Shared with the generator datapath; carry flags that the next term overflows WIDTH.
module fib_step_reg
   import fib_pkg::*;
#(
   parameter int WIDTH = FIB_WIDTH
)
(
   input  logic             clk,
   input  logic             reset,
   input  logic             init,
   input  logic             step,
   output logic [WIDTH-1:0] prev,
   output logic [WIDTH-1:0] curr,
   output logic             carry
);

   logic [WIDTH:0] sum;

   assign sum   = {1'b0, prev} + {1'b0, curr};
   assign carry = sum[WIDTH];

   always_ff @(posedge clk) begin
      if (reset) begin
         prev <= '0;
         curr <= '0;
      end else if (init) begin
         prev <= '0;
         curr <= WIDTH'(1);
      end else if (step) begin
         prev <= curr;
         curr <= sum[WIDTH-1:0];
      end
   end

endmodule

// File: rtl/fib_index_finder.sv
// rtl/fib_index_finder.sv - returns largest k with fib(k) <= value and an exact-match flag
// Optional macro FIB_FLOOR_OUT_EN adds the fib_floor output (fib(index)).
module fib_index_finder
   import fib_pkg::*;
#(
   parameter int WIDTH = FIB_WIDTH,
   parameter int IDX_W = FIB_IDX_W
)
(
   input  logic             clk,
   input  logic             reset,
   input  logic             load_input,
   input  logic [WIDTH-1:0] value,
   output logic             busy,
   output logic             done,
   output logic [IDX_W-1:0] index,
   output logic             is_fib
`ifdef FIB_FLOOR_OUT_EN
   ,
   output logic [WIDTH-1:0] fib_floor
`endif
);

   fib_state_t       state, state_nxt;
   logic [WIDTH-1:0] target;
   logic [IDX_W-1:0] idx, idx_nxt;
   logic [WIDTH-1:0] prev, curr;
   logic             carry;
   logic             init, step;
   logic             res_load;
   logic [IDX_W-1:0] res_idx;
   logic             res_fib;
   logic [WIDTH-1:0] res_floor;

   fib_step_reg #(.WIDTH(WIDTH)) u_step (
      .clk   (clk),
      .reset (reset),
      .init  (init),
      .step  (step),
      .prev  (prev),
      .curr  (curr),
      .carry (carry)
   );

   always_comb begin
      state_nxt = state;
      idx_nxt   = idx;
      init      = 1'b0;
      step      = 1'b0;
      res_load  = 1'b0;
      res_idx   = '0;
      res_fib   = 1'b0;
      res_floor = '0;
      case (state)
         IDLE: begin
            if (load_input) begin
               init    = 1'b1;
               idx_nxt = IDX_W'(1);
               if (value == '0) begin
                  state_nxt = DONE;
                  res_load  = 1'b1;
                  res_fib   = 1'b1;
               end else begin
                  state_nxt = SEARCH;
               end
            end
         end
         SEARCH: begin
            // Equality wins first, so value=1 resolves at idx 1 before the duplicate term.
            if (curr == target) begin
               state_nxt = DONE;
               res_load  = 1'b1;
               res_idx   = idx;
               res_fib   = 1'b1;
               res_floor = curr;
            end else if (curr > target) begin
               state_nxt = DONE;
               res_load  = 1'b1;
               res_idx   = idx - IDX_W'(1);
               res_floor = prev;
            end else if (carry) begin
               state_nxt = DONE;
               res_load  = 1'b1;
               res_idx   = idx;
               res_floor = curr;
            end else begin
               step    = 1'b1;
               idx_nxt = idx + IDX_W'(1);
            end
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= IDLE;
         target <= '0;
         idx    <= '0;
         index  <= '0;
         is_fib <= 1'b0;
      end else begin
         state <= state_nxt;
         idx   <= idx_nxt;
         if (init) begin
            target <= value;
         end
         if (res_load) begin
            index  <= res_idx;
            is_fib <= res_fib;
         end
      end
   end

`ifdef FIB_FLOOR_OUT_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         fib_floor <= '0;
      end else if (res_load) begin
         fib_floor <= res_floor;
      end
   end
`else
   logic unused_floor;
   assign unused_floor = ^res_floor;
`endif

   assign busy = (state == SEARCH);
   assign done = (state == DONE);

endmodule

// File: tb/tb_fib_index_finder.sv
// tb/tb_fib_index_finder.sv - table-driven scoreboard bench for fib_index_finder
module tb_fib_index_finder;

   localparam int W  = 32;
   localparam int IW = 6;
   localparam int NV = 13;

   logic          clk = 1'b0;
   logic          reset;
   logic          load_input;
   logic [W-1:0]  value;
   logic          busy;
   logic          done;
   logic [IW-1:0] index;
   logic          is_fib;
`ifdef FIB_FLOOR_OUT_EN
   logic [W-1:0]  fib_floor;
`endif

   fib_index_finder dut (
      .clk        (clk),
      .reset      (reset),
      .load_input (load_input),
      .value      (value),
      .busy       (busy),
      .done       (done),
      .index      (index),
      .is_fib     (is_fib)
`ifdef FIB_FLOOR_OUT_EN
      ,
      .fib_floor  (fib_floor)
`endif
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] value;
      logic [5:0]  idx;
      logic        fib;
      logic [31:0] floor;
      logic [7:0]  lat;
   } vec_t;

   vec_t vecs [NV];
   vec_t sb [$];
   int   n_pass  = 0;
   int   n_total = 0;

   task automatic check(input string name, input longint act, input longint exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   task automatic run_vec(input vec_t v, input int glitch_cycle, input logic [W-1:0] glitch_val);
      int   lat;
      int   busy_bad;
      vec_t e;
      @(posedge clk); #1;
      load_input = 1'b1;
      value      = v.value;
      sb.push_back(v);
      @(posedge clk); #1;
      load_input = 1'b0;
      value      = ~v.value;
      lat        = 0;
      busy_bad   = 0;
      for (int c = 1; c <= 100; c++) begin
         @(negedge clk);
         if (done) begin
            lat = c;
            break;
         end
         if (!busy) busy_bad++;
         load_input = (c == glitch_cycle);
         if (c == glitch_cycle) value = glitch_val;
      end
      load_input = 1'b0;
      e = sb.pop_front();
      check($sformatf("latency v=%0d", e.value), lat, e.lat);
      check($sformatf("busy_during v=%0d", e.value), busy_bad, 0);
      check($sformatf("busy_at_done v=%0d", e.value), busy, 0);
      check($sformatf("index v=%0d", e.value), index, e.idx);
      check($sformatf("is_fib v=%0d", e.value), is_fib, e.fib);
`ifdef FIB_FLOOR_OUT_EN
      check($sformatf("fib_floor v=%0d", e.value), fib_floor, e.floor);
`endif
      @(negedge clk);
      check($sformatf("done_pulse v=%0d", e.value), done, 0);
      check($sformatf("index_hold v=%0d", e.value), index, e.idx);
   endtask

   initial begin
      vec_t extra;
      vecs[0]  = '{32'd0,          6'd0,  1'b1, 32'd0,          8'd1};
      vecs[1]  = '{32'd13,         6'd7,  1'b1, 32'd13,         8'd8};
      vecs[2]  = '{32'd20,         6'd7,  1'b0, 32'd13,         8'd9};
      vecs[3]  = '{32'd1,          6'd1,  1'b1, 32'd1,          8'd2};
      vecs[4]  = '{32'd2,          6'd3,  1'b1, 32'd2,          8'd4};
      vecs[5]  = '{32'd3,          6'd4,  1'b1, 32'd3,          8'd5};
      vecs[6]  = '{32'd4,          6'd4,  1'b0, 32'd3,          8'd6};
      vecs[7]  = '{32'd7,          6'd5,  1'b0, 32'd5,          8'd7};
      vecs[8]  = '{32'd100,        6'd11, 1'b0, 32'd89,         8'd13};
      vecs[9]  = '{32'd144,        6'd12, 1'b1, 32'd144,        8'd13};
      vecs[10] = '{32'hFFFFFFFF,   6'd47, 1'b0, 32'd2971215073, 8'd48};
      vecs[11] = '{32'd2971215073, 6'd47, 1'b1, 32'd2971215073, 8'd48};
      vecs[12] = '{32'd2971215072, 6'd46, 1'b0, 32'd1836311903, 8'd48};

      reset      = 1'b1;
      load_input = 1'b0;
      value      = '0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check("rst_busy",   busy,   0);
      check("rst_done",   done,   0);
      check("rst_index",  index,  0);
      check("rst_is_fib", is_fib, 0);
`ifdef FIB_FLOOR_OUT_EN
      check("rst_floor",  fib_floor, 0);
`endif

      for (int i = 0; i < NV; i++) run_vec(vecs[i], 0, '0);

      // Load pulse mid-search must not restart or resample.
      extra = '{32'd13, 6'd7, 1'b1, 32'd13, 8'd8};
      run_vec(extra, 3, 32'd2);

      // Reset mid-search with an ignored load pulse in flight.
      @(posedge clk); #1;
      load_input = 1'b1;
      value      = 32'd100;
      @(posedge clk); #1;
      load_input = 1'b0;
      repeat (3) @(negedge clk);
      load_input = 1'b1;
      value      = 32'd5;
      @(negedge clk);
      load_input = 1'b0;
      check("mid_busy_c4", busy, 1);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("mid_rst_busy",   busy,   0);
      check("mid_rst_done",   done,   0);
      check("mid_rst_index",  index,  0);
      check("mid_rst_is_fib", is_fib, 0);
`ifdef FIB_FLOOR_OUT_EN
      check("mid_rst_floor",  fib_floor, 0);
`endif
      @(negedge clk);
      check("post_rst_idle_busy", busy, 0);
      check("post_rst_idle_done", done, 0);
      extra = '{32'd5, 6'd5, 1'b1, 32'd5, 8'd6};
      run_vec(extra, 0, '0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/fib_index_finder.md
Name: fib_index_finder

Overview:
- Inverse of the Fibonacci generator: accepts a value and returns the largest index k with fib(k) <= value, plus a flag saying whether value is exactly a Fibonacci number.
- Convention: fib(0)=0, fib(1)=1.
- Uses the same go/done handshake as the generator controller, so it plugs onto the same host interface as a checker/decoder alongside the generator.

Parameters:
- WIDTH, 32, bit width of input value and internal Fibonacci registers.
- IDX_W, 6, width of index output; must hold the largest index reachable in WIDTH bits (47 for WIDTH=32).

Ports:
- clk, input, 1, single clock; all logic on rising edge.
- reset, input, 1, synchronous, active-high reset.
- load_input, input, 1, go strobe; samples value when idle.
- value, input, WIDTH, number to decode; sampled only with an accepted load_input.
- busy, output, 1, high from the cycle after acceptance until done is asserted.
- done, output, 1, one-cycle pulse when result valid.
- index, output, IDX_W, largest k with fib(k) <= value; held until the next accepted load.
- is_fib, output, 1, 1 when fib(index) == value; held with index.

Behaviour:
- Reset values, applied synchronously on any edge with reset=1 (including mid-search): state=IDLE, busy=0, done=0, index=0, is_fib=0, internal registers 0.
- States:
  - IDLE: wait for load_input.
  - SEARCH: compare and step.
  - DONE: pulse done, then return to IDLE.
- IDLE, load_input=1 (acceptance):
  - Capture target=value; set prev=0, curr=1, idx=1.
  - If value==0: go directly to DONE with index=0, is_fib=1.
  - Otherwise go to SEARCH.
- SEARCH, one compare per cycle, evaluated in priority order:
  - curr==target: index=idx, is_fib=1, go to DONE.
  - curr>target: index=idx-1, is_fib=0, go to DONE.
  - prev+curr carries out of WIDTH: index=idx, is_fib=0, go to DONE. This is the saturation case: no larger representable term exists.
  - Otherwise: prev<=curr, curr<=prev+curr, idx<=idx+1.
- Duplicate 1: value=1 reports index 1, the lowest index, not 2. The step from idx=1 to idx=2 keeps curr=1, and equality was already matched at idx=1.
- Latency, counted from the acceptance edge:
  - Exact match at k>=1: done high in cycle k+1.
  - Non-Fibonacci value with floor index k: done high in cycle k+2.
  - Saturation exit at idx=n: done high in cycle n+1.
  - value=0: done high in cycle 1.
- DONE lasts exactly one cycle; busy=0 in DONE; the next load is accepted in the following IDLE cycle.
- load_input while busy or in DONE is ignored, and value is not resampled.
- index/is_fib update only on the transition into DONE; they are stable otherwise.
- Arithmetic: unsigned; the adder is WIDTH+1 bits, with the MSB used solely as the carry/saturation flag.

Optional Feature:
- Macro FIB_FLOOR_OUT_EN.
- When defined: adds output fib_floor [WIDTH-1:0] = fib(index).
  - Equals curr on an exact or saturation exit, prev on a greater-than exit, 0 for value=0.
  - Registered with index; reset value 0.
- When undefined: the port and its register are absent; all other behaviour is identical.

Decomposition:
- Package fib_pkg:
  - state enum (IDLE, SEARCH, DONE).
  - default WIDTH/IDX_W constants.
  - constant MAX_IDX_32 = 47.
- Sub-module fib_step_reg:
  - prev/curr register pair with WIDTH+1-bit adder.
  - Inputs: init, step. Outputs: prev, curr, carry.
  - Reused by the generator datapath.
- The top module holds the FSM, idx counter, comparators and result registers.

Test Plan:
- value=0, load 1 cycle -> done in cycle 1, index=0, is_fib=1.
- value=13 -> done in cycle 8, index=7, is_fib=1; busy high cycles 1-7.
- value=20 -> done in cycle 9, index=7, is_fib=0 (fib_floor=13 with FIB_FLOOR_OUT_EN).
- value=1 -> index=1, is_fib=1; value=2 -> index=3, is_fib=1.
- value=32'hFFFFFFFF -> saturation exit, index=47, is_fib=0, done in cycle 48; value=2971215073 -> index=47, is_fib=1.
- Search value=100, pulse load_input with value=5 at cycle 3, then reset at cycle 5 -> second load ignored; after reset, outputs 0 and IDLE; a new load with value=5 -> index=5, is_fib=1.
